vend_sequencer: RTL

Central sequencing controller for the soda machine. Latches the drink selection and its price, accumulates coin pulses into a credit register, and decides dispense, change or refund. Runs a request/acknowledge handshake with the OLED display datapath for every finished transaction. Sits between the push-button pulse generators and the display/LED datapath, replacing ad-hoc enable wiring with one explicit state machine.

---
 rtl/vend_pkg.sv | 57 +++++
 rtl/vend_timeout_counter.sv | 31 +++
 rtl/vend_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the soda machine sequencer.
//   - vend_state_t : sequencer state encoding
//   - DISP_*       : codes presented to the OLED display datapath
//   - COIN_*       : coin values in cents
//   - price_of()   : drink price for a one-hot selection (0 when invalid)
//   - sel_valid()  : true for the three legal one-hot selections
//   - coin_value() : coin value by index (0 nickel, 1 dime, 2 quarter)
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_REFUND   = 3'd3,
        ST_SHOW     = 3'd4
    } vend_state_t;

    localparam logic [1:0] DISP_IDLE      = 2'd0;
    localparam logic [1:0] DISP_COLLECT   = 2'd1;
    localparam logic [1:0] DISP_DISPENSED = 2'd2;
    localparam logic [1:0] DISP_REFUNDED  = 2'd3;

    localparam logic [7:0] COIN_NICKEL  = 8'd5;
    localparam logic [7:0] COIN_DIME    = 8'd10;
    localparam logic [7:0] COIN_QUARTER = 8'd25;

    localparam logic [7:0] PRICE_SEL0 = 8'd50;
    localparam logic [7:0] PRICE_SEL1 = 8'd75;
    localparam logic [7:0] PRICE_SEL2 = 8'd100;

    function automatic logic sel_valid(input logic [2:0] sel);
        return (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
    endfunction

    function automatic logic [7:0] price_of(input logic [2:0] sel);
        logic [7:0] p;
        case (sel)
            3'b001:  p = PRICE_SEL0;
            3'b010:  p = PRICE_SEL1;
            3'b100:  p = PRICE_SEL2;
            default: p = 8'd0;
        endcase
        return p;
    endfunction

    function automatic logic [7:0] coin_value(input int idx);
        logic [7:0] v;
        case (idx)
            0:       v = COIN_NICKEL;
            1:       v = COIN_DIME;
            2:       v = COIN_QUARTER;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_timeout_counter.sv
// Idle-cycle counter for the credit collection phase.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear (held while not collecting, pulsed per coin)
//   tc       : terminal count, high while the count equals TIMEOUT-1
// The count stops at TIMEOUT-1 so it can never wrap back below terminal.
module vend_timeout_counter #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (count_reg != TERM) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tc = (count_reg == TERM);

endmodule

// File: rtl/vend_sequencer.sv
// Central sequencing controller for the soda machine.
// Latches the selection price, accumulates coins into credit, decides
// dispense or refund, then handshakes the result with the display.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   sel[2:0], buy                    : one-hot drink select, purchase level
//   coin_nickel/dime/quarter, cancel : single-cycle input pulses
//   disp_ack                         : display consumed disp_code
//   credit, cost, change             : money values in cents (registered)
//   dispense, refund                 : one-cycle result pulses
//   disp_req, disp_code, busy        : display handshake and status
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int TIMEOUT  = 1000000,
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          sel,
    input  logic                buy,
    input  logic                coin_nickel,
    input  logic                coin_dime,
    input  logic                coin_quarter,
    input  logic                cancel,
    input  logic                disp_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] cost,
    output logic [CREDIT_W-1:0] change,
    output logic                dispense,
    output logic                refund,
    output logic                disp_req,
    output logic [1:0]          disp_code,
    output logic                busy
);

    // Sum width is wide enough for a full credit plus all three coins (40).
    localparam int SUM_W = ((CREDIT_W > 6) ? CREDIT_W : 6) + 1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'({CREDIT_W{1'b1}});

    vend_state_t         state_reg;
    logic [CREDIT_W-1:0] credit_reg;
    logic [CREDIT_W-1:0] cost_reg;
    logic [CREDIT_W-1:0] change_reg;
    logic                dispense_reg;
    logic                refund_reg;
    logic                disp_req_reg;
    logic [1:0]          disp_code_reg;
    logic                busy_reg;

    // ------------------------------------------------------------------
    // Coin adder with saturation
    // ------------------------------------------------------------------
    logic [2:0]       coin_vec;
    logic [SUM_W-1:0] coin_term [3];
    logic [SUM_W-1:0] raw_sum;
    logic [CREDIT_W-1:0] credit_next;
    logic             coin_any;

    assign coin_vec = {coin_quarter, coin_dime, coin_nickel};
    assign coin_any = |coin_vec;

    for (genvar gi = 0; gi < 3; gi++) begin : g_coin
        assign coin_term[gi] = coin_vec[gi] ? SUM_W'(coin_value(gi)) : '0;
    end

    always_comb begin
        raw_sum = SUM_W'(credit_reg) + coin_term[0] + coin_term[1] + coin_term[2];
        if (raw_sum > CREDIT_MAX) begin
            credit_next = CREDIT_W'(CREDIT_MAX);
        end else begin
            credit_next = CREDIT_W'(raw_sum);
        end
    end

    // ------------------------------------------------------------------
    // Idle timeout: cleared outside COLLECT (so it starts at 0 on entry)
    // and on every coin pulse.
    // ------------------------------------------------------------------
    logic timeout_clr;
    logic timeout_tc;

    assign timeout_clr = (state_reg != ST_COLLECT) || coin_any;

    vend_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (timeout_clr),
        .tc  (timeout_tc)
    );

    // A coin in the terminal cycle means the customer is still active,
    // so the timeout only fires on a coinless cycle.
    logic refund_cond;
    assign refund_cond = cancel || !buy || (timeout_tc && !coin_any);

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            credit_reg    <= '0;
            cost_reg      <= '0;
            change_reg    <= '0;
            dispense_reg  <= 1'b0;
            refund_reg    <= 1'b0;
            disp_req_reg  <= 1'b0;
            disp_code_reg <= DISP_IDLE;
            busy_reg      <= 1'b0;
        end else begin
            dispense_reg <= 1'b0;
            refund_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (buy) begin
                        if (sel_valid(sel)) begin
                            cost_reg      <= CREDIT_W'(price_of(sel));
                            credit_reg    <= '0;
                            state_reg     <= ST_COLLECT;
                            busy_reg      <= 1'b1;
                            disp_code_reg <= DISP_COLLECT;
                        end else begin
                            cost_reg <= '0;
                        end
                    end
                end
                ST_COLLECT: begin
                    credit_reg <= credit_next;
                    // Reaching the price wins over cancel in the same cycle.
                    if (credit_next >= cost_reg) begin
                        state_reg    <= ST_DISPENSE;
                        dispense_reg <= 1'b1;
                        change_reg   <= credit_next - cost_reg;
                    end else if (refund_cond) begin
                        state_reg  <= ST_REFUND;
                        refund_reg <= 1'b1;
                        change_reg <= credit_next;
                    end
                end
                ST_DISPENSE: begin
                    credit_reg    <= '0;
                    state_reg     <= ST_SHOW;
                    disp_req_reg  <= 1'b1;
                    disp_code_reg <= DISP_DISPENSED;
                end
                ST_REFUND: begin
                    credit_reg    <= '0;
                    state_reg     <= ST_SHOW;
                    disp_req_reg  <= 1'b1;
                    disp_code_reg <= DISP_REFUNDED;
                end
                ST_SHOW: begin
                    if (disp_ack) begin
                        state_reg     <= ST_IDLE;
                        disp_req_reg  <= 1'b0;
                        disp_code_reg <= DISP_IDLE;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    disp_req_reg  <= 1'b0;
                    disp_code_reg <= DISP_IDLE;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign credit    = credit_reg;
    assign cost      = cost_reg;
    assign change    = change_reg;
    assign dispense  = dispense_reg;
    assign refund    = refund_reg;
    assign disp_req  = disp_req_reg;
    assign disp_code = disp_code_reg;
    assign busy      = busy_reg;

endmodule
